// File: rtl/offset_stream_dec.sv
`default_nettype none
// ============================================================================
// Module   : offset_stream_dec
// Purpose  : Receive side of the rolling-offset link. Each incoming beat has
//            the rolling key added to it by the transmitter (data + K). This
//            block subtracts the key (mod 2^N). It then hands the original
//            word downstream over valid/ready through a 2-entry skid buffer.
//            The skid buffer keeps in_ready free of any combinational path
//            from out_ready.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   N        - data and key width in bits
//   STEP     - key increment after each accepted non-last beat (mod 2^N)
//   KEY_INIT - key value after reset and after each packet end
// Ports:
//   clk        in   1  single clock, rising edge
//   resetn     in   1  synchronous active-low reset
//   in_valid   in   1  encoded beat present
//   in_ready   out  1  block can accept a beat (registered state only)
//   in_data    in   N  encoded word (data + key)
//   in_last    in   1  final beat of packet
//   key_load   in   1  overwrite the rolling key
//   key_value  in   N  value for key_load
//   out_valid  out  1  decoded beat present
//   out_ready  in   1  consumer accepts the beat
//   out_data   out  N  decoded word
//   out_last   out  1  in_last carried with the beat
//   dbg_plain  in   N  plaintext of the current input beat (debug builds only)
// Optional build macro:
//   OFFSET_STREAM_DEC_ASSERT_EN - adds protocol assertions, the dbg_plain
//   port, and an end-to-end decode self-check. Behaviour is otherwise
//   identical.
// ============================================================================
module offset_stream_dec #(
    parameter int unsigned N        = 4,
    parameter int unsigned STEP     = 1,
    parameter int unsigned KEY_INIT = 0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_last,
    input  logic         key_load,
    input  logic [N-1:0] key_value,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last
`ifdef OFFSET_STREAM_DEC_ASSERT_EN
    ,
    input  logic [N-1:0] dbg_plain
`endif
);

    localparam logic [1:0]   C_CNT_EMPTY = 2'd0;
    localparam logic [1:0]   C_CNT_ONE   = 2'd1;
    localparam logic [1:0]   C_CNT_FULL  = 2'd2;
    localparam logic [N-1:0] C_KEY_INIT  = N'(KEY_INIT);
    localparam logic [N-1:0] C_STEP      = N'(STEP);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N-1:0] key_q,       key_d;
    logic [1:0]   count_q,     count_d;
    logic [N-1:0] head_data_q, head_data_d;
    logic         head_last_q, head_last_d;
    logic [N-1:0] tail_data_q, tail_data_d;
    logic         tail_last_q, tail_last_d;

    logic         w_accept;
    logic         w_pop;
    logic [N-1:0] w_dec;

    // Handshake outputs come purely from registered state.
    assign in_ready  = (count_q != C_CNT_FULL);
    assign out_valid = (count_q != C_CNT_EMPTY);
    assign out_data  = head_data_q;
    assign out_last  = head_last_q;

    assign w_accept = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    // Subtraction truncates to N bits, so the key wraps mod 2^N. A beat
    // always decodes with the key that was current before this edge, even
    // when key_load rewrites the key on the same edge.
    assign w_dec = in_data - key_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        key_d       = key_q;
        count_d     = count_q;
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;

        // Skid buffer. When the buffer drains, the head keeps its last value,
        // so out_data holds steady while out_valid is low.
        case (count_q)
            C_CNT_EMPTY: begin
                if (w_accept) begin
                    head_data_d = w_dec;
                    head_last_d = in_last;
                    count_d     = C_CNT_ONE;
                end
            end
            C_CNT_ONE: begin
                if (w_accept && w_pop) begin
                    // The head leaves and the new beat replaces it directly.
                    head_data_d = w_dec;
                    head_last_d = in_last;
                end else if (w_accept) begin
                    tail_data_d = w_dec;
                    tail_last_d = in_last;
                    count_d     = C_CNT_FULL;
                end else if (w_pop) begin
                    count_d     = C_CNT_EMPTY;
                end
            end
            default: begin
                // Full: in_ready is low, so only a pop can happen here.
                if (w_pop) begin
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                    count_d     = C_CNT_ONE;
                end
            end
        endcase

        // Key sequencing. An explicit load takes precedence over the
        // per-beat update and discards it.
        if (key_load) begin
            key_d = key_value;
        end else if (w_accept) begin
            if (in_last) begin
                key_d = C_KEY_INIT;
            end else begin
                key_d = key_q + C_STEP;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_q       <= C_KEY_INIT;
            count_q     <= C_CNT_EMPTY;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
        end else begin
            key_q       <= key_d;
            count_q     <= count_d;
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            tail_data_q <= tail_data_d;
            tail_last_q <= tail_last_d;
        end
    end

`ifdef OFFSET_STREAM_DEC_ASSERT_EN
    // ------------------------------------------------------------------
    // Debug self-checks
    // ------------------------------------------------------------------
    // stall_q records that the previous edge saw a stalled output beat. The
    // out_* values seen then must still be present now.
    logic         stall_q;
    logic [N-1:0] stall_data_q;
    logic         stall_last_q;
    // Shadow FIFO of plaintexts. It tracks the real buffer entry for entry,
    // so each popped word can be compared with what was originally sent.
    logic [N-1:0] sh_head_q;
    logic [N-1:0] sh_tail_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_q      <= 1'b0;
            stall_data_q <= '0;
            stall_last_q <= 1'b0;
            sh_head_q    <= '0;
            sh_tail_q    <= '0;
        end else begin
            assert (count_q <= C_CNT_FULL);
            assert (in_ready == (count_q != C_CNT_FULL));
            assert (!w_pop || out_valid);
            if (stall_q) begin
                assert (out_data == stall_data_q);
                assert (out_last == stall_last_q);
            end
            if (w_accept) begin
                assume (in_data == N'(dbg_plain + key_q));
            end
            if (w_pop) begin
                assert (out_data == sh_head_q);
            end

            stall_q      <= out_valid && !out_ready;
            stall_data_q <= out_data;
            stall_last_q <= out_last;

            case (count_q)
                C_CNT_EMPTY: begin
                    if (w_accept) sh_head_q <= dbg_plain;
                end
                C_CNT_ONE: begin
                    if (w_accept && w_pop) sh_head_q <= dbg_plain;
                    else if (w_accept)     sh_tail_q <= dbg_plain;
                end
                default: begin
                    if (w_pop) sh_head_q <= sh_tail_q;
                end
            endcase
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_offset_stream_dec.sv
`default_nettype none
// ============================================================================
// Module   : tb_offset_stream_dec
// Purpose  : Self-checking bench for offset_stream_dec (N=4, STEP=1,
//            KEY_INIT=0). It runs directed steps first and then a random
//            phase. A queue-based reference model predicts every output on
//            every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_offset_stream_dec;

    localparam int unsigned N        = 4;
    localparam int unsigned STEP     = 1;
    localparam int unsigned KEY_INIT = 0;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         in_last;
    logic         key_load;
    logic [N-1:0] key_value;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;

    int checks = 0;
    int errors = 0;

    // Reference model: the key value, a queue of decoded {data,last} entries
    // of capacity 2, and the last word to leave (shown while empty).
    logic [N-1:0] m_key;
    logic [N:0]   mq[$];
    logic [N-1:0] m_hold_d;
    logic         m_hold_l;

    offset_stream_dec #(
        .N        (N),
        .STEP     (STEP),
        .KEY_INIT (KEY_INIT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .key_load  (key_load),
        .key_value (key_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [N-1:0] d, input logic l);
        in_valid = v;
        in_data  = d;
        in_last  = l;
    endtask

    // Compare all outputs against the model, then advance one edge.
    task automatic cyc(input string tag);
        logic [N:0]   e;
        logic [N-1:0] dec;
        logic         acc;
        logic         pop;
        logic [N-1:0] exp_d;
        logic         exp_l;
        if (mq.size() != 0) begin
            e     = mq[0];
            exp_d = e[N:1];
            exp_l = e[0];
        end else begin
            exp_d = m_hold_d;
            exp_l = m_hold_l;
        end
        chk({tag, "_in_ready"},  32'(in_ready),  32'(mq.size() != 2));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
        chk({tag, "_out_data"},  32'(out_data),  32'(exp_d));
        chk({tag, "_out_last"},  32'(out_last),  32'(exp_l));

        @(posedge clk);
        if (!resetn) begin
            mq.delete();
            m_key    = N'(KEY_INIT);
            m_hold_d = '0;
            m_hold_l = 1'b0;
        end else begin
            acc = in_valid && (mq.size() < 2);
            pop = (mq.size() > 0) && out_ready;
            dec = in_data - m_key;
            if (pop) begin
                e        = mq.pop_front();
                m_hold_d = e[N:1];
                m_hold_l = e[0];
            end
            if (acc) mq.push_back({dec, in_last});
            if (key_load)  m_key = key_value;
            else if (acc)  m_key = in_last ? N'(KEY_INIT) : m_key + N'(STEP);
        end
        #1;
    endtask

    initial begin
        resetn    = 1'b0;
        key_load  = 1'b0;
        key_value = '0;
        out_ready = 1'b1;
        drv(1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        mq.delete();
        m_key    = '0;
        m_hold_d = '0;
        m_hold_l = 1'b0;
        #1;
        resetn = 1'b1;

        // Reset state.
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);

        // Basic packet 3,5,7 -> 3,4,5 with last on the third.
        drv(1'b1, 4'd3, 1'b0); cyc("pk0"); chk("pk_d0", 32'(out_data), 32'd3);
        drv(1'b1, 4'd5, 1'b0); cyc("pk1"); chk("pk_d1", 32'(out_data), 32'd4);
        drv(1'b1, 4'd7, 1'b1); cyc("pk2"); chk("pk_d2", 32'(out_data), 32'd5);
        chk("pk_last", 32'(out_last), 32'd1);
        drv(1'b0, '0, 1'b0);   cyc("pk3");

        // Wrap-around: key 15, in 2 -> 3; key then 0 so in 4 -> 4.
        key_load = 1'b1; key_value = 4'd15; cyc("wr0");
        key_load = 1'b0;
        drv(1'b1, 4'd2, 1'b0); cyc("wr1"); chk("wr_d0", 32'(out_data), 32'd3);
        drv(1'b1, 4'd4, 1'b1); cyc("wr2"); chk("wr_d1", 32'(out_data), 32'd4);
        drv(1'b0, '0, 1'b0);   cyc("wr3");

        // Backpressure: three 9s offered while stalled, only two accepted.
        out_ready = 1'b0;
        drv(1'b1, 4'd9, 1'b0); cyc("bp0"); cyc("bp1");
        chk("bp_full_rdy", 32'(in_ready), 32'd0);
        chk("bp_hold0",    32'(out_data), 32'd9);
        cyc("bp2");
        chk("bp_hold1",    32'(out_data), 32'd9);
        out_ready = 1'b1;
        cyc("bp3"); chk("bp_d1", 32'(out_data), 32'd8);
        cyc("bp4"); chk("bp_d2", 32'(out_data), 32'd7);
        drv(1'b0, '0, 1'b0); cyc("bp5");

        // Key now 3: in 0 -> 13 (key 4); then key_load with in 6 -> 2.
        drv(1'b1, 4'd0, 1'b0); cyc("kl0"); chk("kl_d0", 32'(out_data), 32'd13);
        key_load = 1'b1; key_value = 4'd9;
        drv(1'b1, 4'd6, 1'b0); cyc("kl1"); chk("kl_d1", 32'(out_data), 32'd2);
        key_load = 1'b0;
        drv(1'b1, 4'd9, 1'b1); cyc("kl2"); chk("kl_d2", 32'(out_data), 32'd0);
        drv(1'b0, '0, 1'b0);   cyc("kl3");

        // Reset mid-packet with the buffer full.
        out_ready = 1'b0;
        drv(1'b1, 4'd1, 1'b0); cyc("mr0");
        drv(1'b1, 4'd2, 1'b0); cyc("mr1");
        chk("mr_full", 32'(in_ready), 32'd0);
        drv(1'b0, '0, 1'b0); resetn = 1'b0; cyc("mr2");
        resetn = 1'b1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_ready", 32'(in_ready),  32'd1);
        chk("mr_data",  32'(out_data),  32'd0);
        out_ready = 1'b1;
        drv(1'b1, 4'd5, 1'b0); cyc("mr3"); chk("mr_d0", 32'(out_data), 32'd5);
        drv(1'b0, '0, 1'b0);   cyc("mr4");

        // Continuous stream with simultaneous accept and pop.
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 4'($urandom_range(0, 15)), 1'b0);
            cyc("st");
            chk("st_valid", 32'(out_valid), 32'd1);
        end
        drv(1'b0, '0, 1'b0); cyc("st_end");

        // Random phase.
        for (int i = 0; i < 400; i++) begin
            drv(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 3) == 0));
            key_load  = 1'($urandom_range(0, 15) == 0);
            key_value = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 2) != 0);
            resetn    = 1'($urandom_range(0, 63) != 0);
            cyc("rnd");
        end
        resetn = 1'b1; key_load = 1'b0;
        drv(1'b0, '0, 1'b0);
        out_ready = 1'b1;
        cyc("fin0"); cyc("fin1"); cyc("fin2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
